// File: rtl/cfg_tx_pkg.sv
// cfg_tx_pkg: shared FSM state type and a clog2 sizing helper with a 1-bit minimum for cfg_bitstream_tx
package cfg_tx_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cfg_piso.sv
// cfg_piso: parallel-load, shift-enable, LSB-out shift register (clk, rst_n, load, shift, din in; dout = shreg[0])
module cfg_piso #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] din,
  output logic                  dout
);
  logic [WORD_WIDTH-1:0] shreg;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shreg <= '0;
    else if (load) shreg <= din;
    else if (shift) shreg <= shreg >> 1;
  assign dout = shreg[0];
endmodule

// File: rtl/cfg_bitstream_tx.sv
// cfg_bitstream_tx: serialises a sync-read word image LSB-first, word 0 first, onto a 1-bit AXI stream
//   ports: start/busy/done frame control; mem_rd_en/mem_rd_addr/mem_rd_data image memory (data one cycle after rd_en);
//          tvalid/tready/tdata/tlast bitstream master toward the configuration slave
module cfg_bitstream_tx
  import cfg_tx_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 16,
  parameter int ADDR_WIDTH = clog2_min1(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [WORD_WIDTH-1:0] mem_rd_data,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  tdata,
  output logic                  tlast
);
  localparam int BW = clog2_min1(WORD_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [BW-1:0] bit_cnt;
  logic hs, last_bit, last_word, sh_out;
  assign hs        = tvalid & tready;
  assign last_bit  = bit_cnt == LAST_BIT;
  assign last_word = word_idx == LAST_WORD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? FETCH : IDLE;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = SHIFT;
      SHIFT:   state_nx = !(hs && last_bit) ? SHIFT : last_word ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy        = state inside {FETCH, LOAD, SHIFT};
    done        = state == DONE;
    mem_rd_en   = state == FETCH;
    mem_rd_addr = word_idx;
    tvalid      = state == SHIFT;
    tdata       = (state == SHIFT) & sh_out;
    tlast       = (state == SHIFT) & last_word & last_bit;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      word_idx <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == IDLE && start) word_idx <= '0;
      else if (hs && last_bit && !last_word) word_idx <= word_idx + ADDR_WIDTH'(1);
      if (state == LOAD) bit_cnt <= '0;
      else if (hs && !last_bit) bit_cnt <= bit_cnt + BW'(1);
    end
  cfg_piso #(.WORD_WIDTH(WORD_WIDTH)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == LOAD),
    .shift (hs),
    .din   (mem_rd_data),
    .dout  (sh_out)
  );
endmodule

// File: tb/tb_cfg_bitstream_tx.sv
// tb_cfg_bitstream_tx: directed table plus corner-case sequences for a 2-word and a 1-word frame
module tb_cfg_bitstream_tx;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic start2 = 0, tready2 = 0;
  logic busy2, done2, rd_en2, addr2, tvalid2, tdata2, tlast2;
  logic [7:0] rd_data2;
  logic [7:0] img2 [2];
  logic start1 = 0, tready1 = 0;
  logic busy1, done1, rd_en1, addr1, tvalid1, tdata1, tlast1;
  logic [7:0] rd_data1;
  int n_checks = 0, n_fail = 0;
  initial begin
    img2[0] = 8'hA5;
    img2[1] = 8'h3C;
  end
  always_ff @(posedge clk) if (rd_en2) rd_data2 <= img2[addr2];
  always_ff @(posedge clk) if (rd_en1) rd_data1 <= 8'h80;
  cfg_bitstream_tx #(.WORD_WIDTH(8), .NUM_WORDS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .mem_rd_en(rd_en2), .mem_rd_addr(addr2), .mem_rd_data(rd_data2),
    .tvalid(tvalid2), .tready(tready2), .tdata(tdata2), .tlast(tlast2)
  );
  cfg_bitstream_tx #(.WORD_WIDTH(8), .NUM_WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_en(rd_en1), .mem_rd_addr(addr1), .mem_rd_data(rd_data1),
    .tvalid(tvalid1), .tready(tready1), .tdata(tdata1), .tlast(tlast1)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // one row per cycle: inputs driven at the negedge, outputs of that same cycle expected
  typedef struct packed {
    logic start, tready, rd_en, addr, valid, data, last, busy, done;
  } vec_t;
  vec_t tbl [23];
  // runs one frame on dut2, recording handshaken bits and checking AXI hold rules
  task automatic frame2(input bit toggle, output logic [15:0] bits, output int nbits,
                        output int nlast, output int lastpos, output int ndone);
    logic pv, pr, pd, pl;
    int c;
    bits = '0; nbits = 0; nlast = 0; lastpos = -1; ndone = 0;
    pv = 0; pr = 0; pd = 0; pl = 0;
    @(negedge clk); start2 = 1; tready2 = 1;
    @(negedge clk); start2 = 0;
    c = 0;
    while (ndone == 0 && c < 200) begin
      if (toggle) tready2 = ~tready2;
      if (pv && !pr) begin
        check("hold_valid", 32'(tvalid2), 1);
        check("hold_data", 32'(tdata2), 32'(pd));
        check("hold_last", 32'(tlast2), 32'(pl));
      end
      if (tvalid2 && tready2) begin
        if (nbits < 16) bits[nbits] = tdata2;
        if (tlast2) begin nlast++; lastpos = nbits; end
        nbits++;
      end
      if (done2) ndone++;
      pv = tvalid2; pr = tready2; pd = tdata2; pl = tlast2;
      c++;
      if (ndone == 0) @(negedge clk);
    end
    check("frame_timeout", 32'(ndone), 1);
    @(negedge clk);
    check("done_single_pulse", 32'(done2), 0);
    check("busy_after_frame", 32'(busy2), 0);
  endtask
  initial begin
    logic [15:0] bits;
    logic [7:0] bits1;
    int nbits, nlast, lastpos, ndone, nhs;
    //            st rdy rd ad v  d  l  b  dn
    tbl[0]  = 9'b1__1__0__0__0__0__0__0__0;
    tbl[1]  = 9'b0__1__1__0__0__0__0__1__0;
    tbl[2]  = 9'b0__1__0__0__0__0__0__1__0;
    tbl[3]  = 9'b0__1__0__0__1__1__0__1__0;
    tbl[4]  = 9'b0__1__0__0__1__0__0__1__0;
    tbl[5]  = 9'b0__1__0__0__1__1__0__1__0;
    tbl[6]  = 9'b0__1__0__0__1__0__0__1__0;
    tbl[7]  = 9'b0__1__0__0__1__0__0__1__0;
    tbl[8]  = 9'b0__1__0__0__1__1__0__1__0;
    tbl[9]  = 9'b0__1__0__0__1__0__0__1__0;
    tbl[10] = 9'b0__1__0__0__1__1__0__1__0;
    tbl[11] = 9'b0__1__1__1__0__0__0__1__0;
    tbl[12] = 9'b0__1__0__1__0__0__0__1__0;
    tbl[13] = 9'b0__1__0__1__1__0__0__1__0;
    tbl[14] = 9'b0__1__0__1__1__0__0__1__0;
    tbl[15] = 9'b0__1__0__1__1__1__0__1__0;
    tbl[16] = 9'b0__1__0__1__1__1__0__1__0;
    tbl[17] = 9'b0__1__0__1__1__1__0__1__0;
    tbl[18] = 9'b0__1__0__1__1__1__0__1__0;
    tbl[19] = 9'b0__1__0__1__1__0__0__1__0;
    tbl[20] = 9'b0__1__0__1__1__0__1__1__0;
    tbl[21] = 9'b0__1__0__1__0__0__0__0__1;
    tbl[22] = 9'b0__1__0__0__0__0__0__0__0;
    // reset values
    @(negedge clk); @(negedge clk);
    check("rst_busy", 32'(busy2), 0);
    check("rst_done", 32'(done2), 0);
    check("rst_rd_en", 32'(rd_en2), 0);
    check("rst_addr", 32'(addr2), 0);
    check("rst_tvalid", 32'(tvalid2), 0);
    check("rst_tdata", 32'(tdata2), 0);
    check("rst_tlast", 32'(tlast2), 0);
    check("rst_tvalid1", 32'(tvalid1), 0);
    rst_n = 1;
    @(negedge clk);
    // cycle-exact frame with tready held high
    for (int i = 0; i < 23; i++) begin
      start2 = tbl[i].start;
      tready2 = tbl[i].tready;
      check($sformatf("tbl%0d_rd_en", i), 32'(rd_en2), 32'(tbl[i].rd_en));
      if (tbl[i].rd_en) check($sformatf("tbl%0d_addr", i), 32'(addr2), 32'(tbl[i].addr));
      check($sformatf("tbl%0d_tvalid", i), 32'(tvalid2), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        check($sformatf("tbl%0d_tdata", i), 32'(tdata2), 32'(tbl[i].data));
        check($sformatf("tbl%0d_tlast", i), 32'(tlast2), 32'(tbl[i].last));
      end
      check($sformatf("tbl%0d_busy", i), 32'(busy2), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_done", i), 32'(done2), 32'(tbl[i].done));
      @(negedge clk);
    end
    // tready toggling: same bits, held while stalled
    frame2(1, bits, nbits, nlast, lastpos, ndone);
    check("toggle_bits", 32'(bits), 32'h3CA5);
    check("toggle_nbits", 32'(nbits), 16);
    check("toggle_nlast", 32'(nlast), 1);
    check("toggle_lastpos", 32'(lastpos), 15);
    // start during SHIFT and during DONE is ignored
    tready2 = 1;
    @(negedge clk); start2 = 1;
    @(negedge clk); start2 = 0;
    nhs = 0; ndone = 0;
    for (int c = 0; c < 60; c++) begin
      start2 = (c == 5) || done2;
      if (tvalid2 && tready2) nhs++;
      if (done2) ndone++;
      if (c > 30) check("ignored_start_busy", 32'(busy2), 0);
      @(negedge clk);
    end
    start2 = 0;
    check("ignored_start_hs", 32'(nhs), 16);
    check("ignored_start_done", 32'(ndone), 1);
    // asynchronous reset mid word 1, then full resend
    @(negedge clk); start2 = 1;
    @(negedge clk); start2 = 0;
    repeat (13) @(negedge clk);
    check("pre_rst_tvalid", 32'(tvalid2), 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_tvalid", 32'(tvalid2), 0);
    check("async_rst_busy", 32'(busy2), 0);
    check("async_rst_done", 32'(done2), 0);
    @(negedge clk); rst_n = 1;
    frame2(0, bits, nbits, nlast, lastpos, ndone);
    check("resend_bits", 32'(bits), 32'h3CA5);
    check("resend_nbits", 32'(nbits), 16);
    check("resend_lastpos", 32'(lastpos), 15);
    // single-word frame
    @(negedge clk); start1 = 1; tready1 = 1;
    @(negedge clk); start1 = 0;
    bits1 = '0; nbits = 0; nlast = 0; lastpos = -1; ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (rd_en1) check("nw1_addr", 32'(addr1), 0);
      if (tvalid1 && tready1) begin
        if (nbits < 8) bits1[nbits] = tdata1;
        if (tlast1) begin nlast++; lastpos = nbits; end
        nbits++;
      end
      if (done1) ndone++;
      @(negedge clk);
    end
    check("nw1_bits", 32'(bits1), 32'h80);
    check("nw1_nbits", 32'(nbits), 8);
    check("nw1_nlast", 32'(nlast), 1);
    check("nw1_lastpos", 32'(lastpos), 7);
    check("nw1_done", 32'(ndone), 1);
    check("nw1_busy", 32'(busy1), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
